// File: rtl/mem_cmd_initiator.sv
// Initiator side of the memory command bus: sends a 4-byte command header, waits for
// the target ack, then streams write payload out or collects read payload back.
module mem_cmd_initiator #(
    parameter int unsigned DATA_BYTES  = 32,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic [2:0]  in_req_dest,
    input  logic [1:0]  in_req_opcode,
    input  logic        in_req_enc_type,
    input  logic [23:0] in_req_addr,
    input  logic        in_wr_valid,
    input  logic [7:0]  in_wr_data,
    output logic        out_wr_ready,
    output logic        out_rd_valid,
    output logic [7:0]  out_rd_data,
    input  logic        in_rd_ready,
    output logic [7:0]  out_bus,
    output logic        out_bus_valid,
    input  logic        in_bus_ready,
    input  logic [7:0]  in_bus,
    input  logic        in_bus_valid,
    output logic        out_bus_ready,
    input  logic        in_ack_req,
    input  logic [2:0]  in_ack_id,
    output logic        out_ack_success,
    output logic        out_done,
    output logic        out_err
);

    localparam int unsigned BCNT_W = $clog2(DATA_BYTES + 1);
    localparam int unsigned TCNT_W = $clog2(ACK_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, HDR, ADDR2, ADDR1, ADDR0, WAIT_ACK, WR_DATA, RD_DATA, DONE, ERR
    } state_t;

    state_t              state, state_d;
    logic [2:0]          dest_q, dest_d;
    logic [1:0]          opcode_q, opcode_d;
    logic [23:0]         addr_q, addr_d;
    logic [BCNT_W-1:0]   bcnt, bcnt_d;
    logic [TCNT_W-1:0]   tcnt, tcnt_d;
    logic [7:0]          bus_d, rd_data_d;
    logic                bus_valid_d, rd_valid_d;
    logic                req_ready_d, done_d, err_d;
    logic                bus_xfer, ack_match, wr_room, rd_room;

    // Handshake qualifiers; the ready outputs follow the same-cycle downstream ready
    assign bus_xfer        = out_bus_valid & in_bus_ready;
    assign ack_match       = in_ack_req & (in_ack_id == dest_q);
    assign wr_room         = (32'(bcnt) + 32'(out_bus_valid)) < DATA_BYTES;
    assign rd_room         = 32'(bcnt) < DATA_BYTES;
    assign out_wr_ready    = (state == WR_DATA) & (~out_bus_valid | in_bus_ready) & wr_room;
    assign out_bus_ready   = (state == RD_DATA) & (~out_rd_valid | in_rd_ready) & rd_room;
    assign out_ack_success = (state == WAIT_ACK) & ack_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dest_q        <= '0;
            opcode_q      <= '0;
            addr_q        <= '0;
            bcnt          <= '0;
            tcnt          <= '0;
            out_bus       <= '0;
            out_bus_valid <= 1'b0;
            out_rd_data   <= '0;
            out_rd_valid  <= 1'b0;
            out_req_ready <= 1'b1;
            out_done      <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            state         <= state_d;
            dest_q        <= dest_d;
            opcode_q      <= opcode_d;
            addr_q        <= addr_d;
            bcnt          <= bcnt_d;
            tcnt          <= tcnt_d;
            out_bus       <= bus_d;
            out_bus_valid <= bus_valid_d;
            out_rd_data   <= rd_data_d;
            out_rd_valid  <= rd_valid_d;
            out_req_ready <= req_ready_d;
            out_done      <= done_d;
            out_err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        dest_d      = dest_q;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt;
        tcnt_d      = tcnt;
        bus_d       = out_bus;
        bus_valid_d = out_bus_valid;
        rd_data_d   = out_rd_data;
        rd_valid_d  = out_rd_valid;

        unique case (state)
            IDLE: begin
                if (in_req_valid) begin
                    dest_d      = in_req_dest;
                    opcode_d    = in_req_opcode;
                    addr_d      = in_req_addr;
                    bcnt_d      = '0;
                    tcnt_d      = '0;
                    bus_d       = {in_req_dest, in_req_opcode, in_req_enc_type, 2'b00};
                    bus_valid_d = 1'b1;
                    state_d     = HDR;
                end
            end
            HDR: begin
                if (bus_xfer) begin
                    bus_valid_d = 1'b0;
                    state_d     = ADDR2;
                end
            end
            // Address bytes: load in the cycle after the previous transfer, then hold
            ADDR2: begin
                if (!out_bus_valid) begin
                    bus_d       = addr_q[23:16];
                    bus_valid_d = 1'b1;
                end else if (in_bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = ADDR1;
                end
            end
            ADDR1: begin
                if (!out_bus_valid) begin
                    bus_d       = addr_q[15:8];
                    bus_valid_d = 1'b1;
                end else if (in_bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = ADDR0;
                end
            end
            ADDR0: begin
                if (!out_bus_valid) begin
                    bus_d       = addr_q[7:0];
                    bus_valid_d = 1'b1;
                end else if (in_bus_ready) begin
                    bus_valid_d = 1'b0;
                    tcnt_d      = '0;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    if (opcode_q[1])      state_d = DONE;
                    else if (opcode_q[0]) state_d = WR_DATA;
                    else                  state_d = RD_DATA;
                end else if (tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end
            WR_DATA: begin
                if (bus_xfer) bcnt_d = bcnt + BCNT_W'(1);
                if (out_wr_ready && in_wr_valid) begin
                    bus_d       = in_wr_data;
                    bus_valid_d = 1'b1;
                end else if (bus_xfer) begin
                    bus_valid_d = 1'b0;
                end
                if (bus_xfer && (32'(bcnt) + 32'd1 == DATA_BYTES)) state_d = DONE;
            end
            RD_DATA: begin
                if (in_bus_valid && out_bus_ready) begin
                    rd_data_d  = in_bus;
                    rd_valid_d = 1'b1;
                    bcnt_d     = bcnt + BCNT_W'(1);
                end else if (out_rd_valid && in_rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (!rd_room) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

endmodule

// File: tb/tb_mem_cmd_initiator.sv
// Scoreboard bench for mem_cmd_initiator: directed scenarios plus randomized commands.
`timescale 1ns/1ps
module tb_mem_cmd_initiator;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 8;

    logic        clk, rst_n;
    logic        in_req_valid, out_req_ready;
    logic [2:0]  in_req_dest;
    logic [1:0]  in_req_opcode;
    logic        in_req_enc_type;
    logic [23:0] in_req_addr;
    logic        in_wr_valid, out_wr_ready;
    logic [7:0]  in_wr_data;
    logic        out_rd_valid, in_rd_ready;
    logic [7:0]  out_rd_data;
    logic [7:0]  out_bus, in_bus;
    logic        out_bus_valid, in_bus_ready, in_bus_valid, out_bus_ready;
    logic        in_ack_req;
    logic [2:0]  in_ack_id;
    logic        out_ack_success, out_done, out_err;

    mem_cmd_initiator #(.DATA_BYTES(DB), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_req_dest(in_req_dest), .in_req_opcode(in_req_opcode),
        .in_req_enc_type(in_req_enc_type), .in_req_addr(in_req_addr),
        .in_wr_valid(in_wr_valid), .in_wr_data(in_wr_data), .out_wr_ready(out_wr_ready),
        .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data), .in_rd_ready(in_rd_ready),
        .out_bus(out_bus), .out_bus_valid(out_bus_valid), .in_bus_ready(in_bus_ready),
        .in_bus(in_bus), .in_bus_valid(in_bus_valid), .out_bus_ready(out_bus_ready),
        .in_ack_req(in_ack_req), .in_ack_id(in_ack_id),
        .out_ack_success(out_ack_success), .out_done(out_done), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] bus_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] pay [DB];
    int bus_rdy_mode, rd_rdy_mode;   // 0 always ready, 1 toggle, 2 random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bytes whenever the DUT completes a transfer
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("bus_hold_valid", 32'(out_bus_valid), 32'd1);
                check("bus_hold_data", 32'(out_bus), 32'(prev_byte));
            end
            if (out_bus_valid && in_bus_ready) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got byte 0x%0h with none expected", out_bus);
                end else begin
                    check("bus_byte", 32'(out_bus), 32'(bus_q.pop_front()));
                end
            end
            prev_hold = out_bus_valid && !in_bus_ready;
            prev_byte = out_bus;
            if (out_rd_valid && in_rd_ready) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got byte 0x%0h with none expected", out_rd_data);
                end else begin
                    check("rd_byte", 32'(out_rd_data), 32'(rd_q.pop_front()));
                end
            end
            if (out_rd_valid && !in_rd_ready)
                check("rd_backpressure", 32'(out_bus_ready), 32'd0);
            ack_cnt  += int'(out_ack_success);
            done_cnt += int'(out_done);
            err_cnt  += int'(out_err);
        end
    end

    // Runs one command; starts and ends just after a rising edge
    task automatic run_cmd(input logic [2:0] dest, input logic [1:0] op, input logic enc,
                           input logic [23:0] addr, input int ack_dly, input logic bad_ack,
                           input logic [2:0] bad_id, input logic no_ack, input int rst_after,
                           input logic stall_rd);
        logic [7:0] hdr;
        int hdr_seen = 0, pay_seen = 0, wr_fed = 0, rd_fed = 0, rd_taken = 0;
        int stall_left = 0, since_wait = -1, ack_timer = 0, ack_stage = 0, cyc;
        int ack0, done0, err0;
        bit finished = 0, did_reset = 0, stall_used = 0;
        logic req_go, hdr_go, pay_go, wr_go, rdb_go, take_go, ack_go;
        hdr = {dest, op, enc, 2'b00};
        bus_q.push_back(hdr);
        bus_q.push_back(addr[23:16]);
        bus_q.push_back(addr[15:8]);
        bus_q.push_back(addr[7:0]);
        if (!no_ack && op == 2'b01) for (int i = 0; i < DB; i++) bus_q.push_back(pay[i]);
        if (!no_ack && op == 2'b00) for (int i = 0; i < DB; i++) rd_q.push_back(pay[i]);
        ack0 = ack_cnt; done0 = done_cnt; err0 = err_cnt;
        in_req_valid = 1'b1; in_req_dest = dest; in_req_opcode = op;
        in_req_enc_type = enc; in_req_addr = addr;
        in_wr_valid = (op == 2'b01); in_wr_data = pay[0];
        for (cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            req_go  = in_req_valid & out_req_ready;
            hdr_go  = out_bus_valid & in_bus_ready & (hdr_seen < 4);
            pay_go  = out_bus_valid & in_bus_ready & (hdr_seen >= 4);
            wr_go   = in_wr_valid & out_wr_ready;
            rdb_go  = in_bus_valid & out_bus_ready;
            take_go = out_rd_valid & in_rd_ready;
            ack_go  = in_ack_req & out_ack_success;
            if (in_ack_req && in_ack_id != dest)
                check("no_ack_for_wrong_id", 32'(out_ack_success), 32'd0);
            if (op == 2'b01 && wr_fed == int'(DB))
                check("wr_ready_after_last", 32'(out_wr_ready), 32'd0);
            if (since_wait >= 0) since_wait++;
            if (out_err) begin
                if (no_ack) check("err_latency", 32'(since_wait - 1), 32'(TO));
                finished = 1;
            end
            if (out_done) finished = 1;
            @(posedge clk); #1;
            if (req_go) in_req_valid = 1'b0;
            if (hdr_go) begin
                hdr_seen++;
                if (hdr_seen == 4) begin since_wait = 0; ack_timer = ack_dly; end
            end
            if (pay_go) pay_seen++;
            if (since_wait >= 0 && !no_ack) begin
                if (ack_go) begin
                    in_ack_req = 1'b0; ack_stage = 3;
                end else if (ack_stage == 1) begin
                    in_ack_id = dest; ack_stage = 2;
                end else if (ack_stage == 0) begin
                    if (ack_timer == 0) begin
                        in_ack_req = 1'b1;
                        in_ack_id  = bad_ack ? bad_id : dest;
                        ack_stage  = bad_ack ? 1 : 2;
                    end else begin
                        ack_timer--;
                    end
                end
            end
            if (wr_go) wr_fed++;
            if (op == 2'b01) in_wr_data = (wr_fed < int'(DB)) ? pay[wr_fed] : 8'hEE;
            if (rdb_go) rd_fed++;
            in_bus_valid = (op == 2'b00 && rd_fed < int'(DB)) &&
                           (rd_rdy_mode != 2 || $urandom_range(0, 3) != 0);
            in_bus = (rd_fed < int'(DB)) ? pay[rd_fed] : 8'h00;
            if (take_go) rd_taken++;
            case (bus_rdy_mode)
                0:       in_bus_ready = 1'b1;
                1:       in_bus_ready = ~in_bus_ready;
                default: in_bus_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall_rd && rd_taken == 1 && !stall_used) begin
                stall_left = 3; stall_used = 1;
            end
            if (stall_left > 0) begin
                in_rd_ready = 1'b0; stall_left--;
            end else begin
                case (rd_rdy_mode)
                    0:       in_rd_ready = 1'b1;
                    1:       in_rd_ready = ~in_rd_ready;
                    default: in_rd_ready = 1'($urandom_range(0, 1));
                endcase
            end
            if (rst_after > 0 && pay_seen == rst_after && !did_reset) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_req_ready", 32'(out_req_ready), 32'd1);
                check("rst_bus_valid", 32'(out_bus_valid), 32'd0);
                check("rst_bus", 32'(out_bus), 32'd0);
                check("rst_wr_ready", 32'(out_wr_ready), 32'd0);
                check("rst_rd_valid", 32'(out_rd_valid), 32'd0);
                check("rst_done_err", 32'({out_done, out_err, out_ack_success}), 32'd0);
                bus_q.delete(); rd_q.delete();
                in_wr_valid = 1'b0; in_bus_valid = 1'b0; in_ack_req = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                did_reset = 1; finished = 1;
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: command op=%0d still busy after %0d cycles", op, cyc);
        end
        in_req_valid = 1'b0; in_wr_valid = 1'b0; in_bus_valid = 1'b0; in_ack_req = 1'b0;
        @(negedge clk);
        check("req_ready_after", 32'(out_req_ready), 32'd1);
        check("ack_count", 32'(ack_cnt - ack0), no_ack ? 32'd0 : 32'd1);
        check("done_count", 32'(done_cnt - done0), (no_ack || did_reset) ? 32'd0 : 32'd1);
        check("err_count", 32'(err_cnt - err0), no_ack ? 32'd1 : 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_req_valid = 1'b0; in_req_dest = '0; in_req_opcode = '0; in_req_enc_type = 1'b0;
        in_req_addr = '0; in_wr_valid = 1'b0; in_wr_data = '0; in_rd_ready = 1'b1;
        in_bus = '0; in_bus_valid = 1'b0; in_bus_ready = 1'b1; in_ack_req = 1'b0; in_ack_id = '0;
        bus_rdy_mode = 0; rd_rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(out_req_ready), 32'd1);
        check("reset_bus_valid", 32'(out_bus_valid), 32'd0);
        check("reset_rd_valid", 32'(out_rd_valid), 32'd0);
        check("reset_pulses", 32'({out_done, out_err, out_ack_success}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Control command
        run_cmd(3'd2, 2'b10, 1'b1, 24'h123456, 2, 1'b0, 3'd0, 1'b0, 0, 1'b0);
        // Write with toggling bus ready
        bus_rdy_mode = 1;
        for (int i = 0; i < DB; i++) pay[i] = 8'hA0 + 8'(i);
        run_cmd(3'd1, 2'b01, 1'b0, 24'h00ABCD, 1, 1'b0, 3'd0, 1'b0, 0, 1'b0);
        // Read with host stall mid-stream
        bus_rdy_mode = 0;
        for (int i = 0; i < DB; i++) pay[i] = 8'h11 * 8'(i + 1);
        run_cmd(3'd4, 2'b00, 1'b0, 24'h000010, 1, 1'b0, 3'd0, 1'b0, 0, 1'b1);
        // Wrong ack id first
        run_cmd(3'd3, 2'b10, 1'b0, 24'h0F0F0F, 1, 1'b1, 3'd5, 1'b0, 0, 1'b0);
        // Ack timeout
        run_cmd(3'd6, 2'b11, 1'b1, 24'hFEDCBA, 0, 1'b0, 3'd0, 1'b1, 0, 1'b0);
        // Reset mid-write, then a normal write
        for (int i = 0; i < DB; i++) pay[i] = 8'($urandom);
        run_cmd(3'd5, 2'b01, 1'b1, 24'h5A5A5A, 0, 1'b0, 3'd0, 1'b0, 2, 1'b0);
        run_cmd(3'd5, 2'b01, 1'b1, 24'hA5A5A5, 0, 1'b0, 3'd0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [2:0] d;
            d = 3'($urandom);
            for (int i = 0; i < DB; i++) pay[i] = 8'($urandom);
            bus_rdy_mode = int'($urandom_range(0, 2));
            rd_rdy_mode  = int'($urandom_range(0, 2));
            run_cmd(d, 2'($urandom), 1'($urandom), 24'($urandom),
                    int'($urandom_range(0, 4)), 1'($urandom), d ^ 3'($urandom_range(1, 7)),
                    $urandom_range(0, 5) == 0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
